pma_unit: RTL and testbench

- Programmable, multi-channel Physical Memory Attribute checker; successor to the fixed three-region combinational PMA.
- NUM_REGIONS runtime-configurable address/mask regions with enable, lock, cacheability, memregion and R/W/X attributes.
- Serves NUM_CH independent lookup channels (e.g. ch0 = fetch, ch1 = LSU) with registered valid/ready responses.
- Captures the first access fault for trap/debug. Sits between the core front-end/LSU and the cache/bus select logic.

---
 rtl/pma_unit_pkg.sv | 59 +++++
 rtl/pma_unit_match.sv | 49 ++++
 rtl/pma_unit.sv | 179 +++++++++++++++++
 tb/tb_pma_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pma_unit_pkg.sv
// Shared types and constants for the programmable PMA checker.
package pma_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Attribute word bit positions
  localparam int unsigned AttrR         = 0;
  localparam int unsigned AttrW         = 1;
  localparam int unsigned AttrX         = 2;
  localparam int unsigned AttrUncached  = 3;
  localparam int unsigned AttrMemregion = 4;
  localparam int unsigned AttrEnable    = 5;
  localparam int unsigned AttrLock      = 7;

  typedef struct packed {
    logic lock;
    logic rsvd;
    logic enable;
    logic memregion;
    logic uncached;
    logic x;
    logic w;
    logic r;
  } pma_attr_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] mask;
    pma_attr_t       attr;
  } pma_region_t;

  typedef enum logic [1:0] {
    PMA_R = 2'd0,
    PMA_W = 2'd1,
    PMA_X = 2'd2
  } pma_acc_e;

  typedef enum logic [1:0] {
    CfgAddr = 2'd0,
    CfgMask = 2'd1,
    CfgAttr = 2'd2,
    CfgRsvd = 2'd3
  } cfg_sel_e;

  // Reserved bit is never stored.
  function automatic pma_attr_t attr_from_word(logic [XLEN-1:0] word);
    pma_attr_t a;
    a           = '0;
    a.r         = word[AttrR];
    a.w         = word[AttrW];
    a.x         = word[AttrX];
    a.uncached  = word[AttrUncached];
    a.memregion = word[AttrMemregion];
    a.enable    = word[AttrEnable];
    a.lock      = word[AttrLock];
    return a;
  endfunction

endpackage

// File: rtl/pma_unit_match.sv
// Combinational priority matcher: lowest enabled matching region supplies the attributes.
module pma_match
  import pma_unit_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8,
  localparam int unsigned IdxW = $clog2(NUM_REGIONS)
) (
  input  pma_region_t [NUM_REGIONS-1:0] regions_i,
  input  logic [XLEN-1:0]               addr_i,
  input  logic [1:0]                    acc_i,
  output logic                          grant_o,
  output logic                          uncached_o,
  output logic                          memregion_o,
  output logic [IdxW-1:0]               region_o
);

  logic      hit;
  pma_attr_t hit_attr;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_attr = '0;
    region_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (regions_i[i].attr.enable &&
          ((addr_i & ~regions_i[i].mask) == regions_i[i].addr)) begin
        hit      = 1'b1;
        hit_attr = regions_i[i].attr;
        region_o = IdxW'(i);
      end
    end
  end

  always_comb begin
    grant_o = 1'b0;
    if (hit) begin
      case (pma_acc_e'(acc_i))
        PMA_R:   grant_o = hit_attr.r;
        PMA_W:   grant_o = hit_attr.w;
        PMA_X:   grant_o = hit_attr.x;
        default: grant_o = 1'b0;
      endcase
    end
    uncached_o  = hit ? hit_attr.uncached : 1'b1;
    memregion_o = hit ? hit_attr.memregion : 1'b0;
  end

endmodule

// File: rtl/pma_unit.sv
// Programmable multi-channel PMA checker with registered responses and first-fault capture.
module pma_unit
  import pma_unit_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter logic [31:0] RST_ADDR    = 32'h4000_0000,
  parameter logic [31:0] RST_MASK    = 32'h000F_FFFF,
  localparam int unsigned IdxW = $clog2(NUM_REGIONS),
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CH-1:0]      req_valid_i,
  output logic [NUM_CH-1:0]      req_ready_o,
  input  logic [NUM_CH*XLEN-1:0] req_addr_i,
  input  logic [NUM_CH*2-1:0]    req_acc_i,
  output logic [NUM_CH-1:0]      rsp_valid_o,
  input  logic [NUM_CH-1:0]      rsp_ready_i,
  output logic [NUM_CH-1:0]      rsp_grant_o,
  output logic [NUM_CH-1:0]      rsp_uncached_o,
  output logic [NUM_CH-1:0]      rsp_memregion_o,
  output logic [NUM_CH*IdxW-1:0] rsp_region_o,
  input  logic                   cfg_we_i,
  input  logic [IdxW-1:0]        cfg_idx_i,
  input  logic [1:0]             cfg_sel_i,
  input  logic [XLEN-1:0]        cfg_wdata_i,
  output logic                   cfg_err_o,
  output logic                   fault_valid_o,
  output logic [XLEN-1:0]        fault_addr_o,
  output logic [ChW-1:0]         fault_ch_o,
  input  logic                   fault_clr_i
);

  localparam pma_region_t RstRegion0 = '{
    addr: RST_ADDR,
    mask: RST_MASK,
    attr: '{lock: 1'b0, rsvd: 1'b0, enable: 1'b1, memregion: 1'b1, uncached: 1'b0,
            x: 1'b1, w: 1'b1, r: 1'b1}
  };

  pma_region_t [NUM_REGIONS-1:0] regions_q, regions_d;
  logic                          cfg_err_q, cfg_err_d;

  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0]            m_grant, m_uncached, m_memregion;
  logic [NUM_CH-1:0][IdxW-1:0]  m_region;

  logic [NUM_CH-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_CH-1:0]            rsp_grant_q, rsp_grant_d;
  logic [NUM_CH-1:0]            rsp_uncached_q, rsp_uncached_d;
  logic [NUM_CH-1:0]            rsp_memregion_q, rsp_memregion_d;
  logic [NUM_CH-1:0][IdxW-1:0]  rsp_region_q, rsp_region_d;

  logic                         fault_valid_q, fault_valid_d;
  logic [XLEN-1:0]              fault_addr_q, fault_addr_d;
  logic [ChW-1:0]               fault_ch_q, fault_ch_d;
  logic                         fault_hit;
  logic [XLEN-1:0]              fault_hit_addr;
  logic [ChW-1:0]               fault_hit_ch;

  assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;

  // Matchers see regions_q, so a same-cycle config write only affects later accepts.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pma_match #(
      .NUM_REGIONS (NUM_REGIONS)
    ) u_match (
      .regions_i   (regions_q),
      .addr_i      (req_addr_i[c*XLEN +: XLEN]),
      .acc_i       (req_acc_i[c*2 +: 2]),
      .grant_o     (m_grant[c]),
      .uncached_o  (m_uncached[c]),
      .memregion_o (m_memregion[c]),
      .region_o    (m_region[c])
    );
  end

  always_comb begin
    regions_d = regions_q;
    cfg_err_d = 1'b0;
    if (cfg_we_i) begin
      if ((cfg_sel_e'(cfg_sel_i) == CfgRsvd) || regions_q[cfg_idx_i].attr.lock) begin
        cfg_err_d = 1'b1;
      end else begin
        case (cfg_sel_e'(cfg_sel_i))
          CfgAddr: regions_d[cfg_idx_i].addr = cfg_wdata_i;
          CfgMask: regions_d[cfg_idx_i].mask = cfg_wdata_i;
          CfgAttr: regions_d[cfg_idx_i].attr = attr_from_word(cfg_wdata_i);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rsp_valid_d     = rsp_valid_q;
    rsp_grant_d     = rsp_grant_q;
    rsp_uncached_d  = rsp_uncached_q;
    rsp_memregion_d = rsp_memregion_q;
    rsp_region_d    = rsp_region_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) begin
        rsp_valid_d[c]     = 1'b1;
        rsp_grant_d[c]     = m_grant[c];
        rsp_uncached_d[c]  = m_uncached[c];
        rsp_memregion_d[c] = m_memregion[c];
        rsp_region_d[c]    = m_region[c];
      end else if (rsp_ready_i[c]) begin
        rsp_valid_d[c] = 1'b0;
      end
    end
  end

  always_comb begin
    fault_hit      = 1'b0;
    fault_hit_addr = '0;
    fault_hit_ch   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (accept[c] && !m_grant[c]) begin
        fault_hit      = 1'b1;
        fault_hit_addr = req_addr_i[c*XLEN +: XLEN];
        fault_hit_ch   = ChW'(c);
      end
    end
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_ch_d    = fault_ch_q;
    if (fault_clr_i) begin
      fault_valid_d = 1'b0;
    end
    // A new fault coinciding with a clear is still captured.
    if (fault_hit && (!fault_valid_q || fault_clr_i)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = fault_hit_addr;
      fault_ch_d    = fault_hit_ch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        regions_q[i] <= (i == 0) ? RstRegion0 : '0;
      end
      cfg_err_q       <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_grant_q     <= '0;
      rsp_uncached_q  <= '0;
      rsp_memregion_q <= '0;
      rsp_region_q    <= '0;
      fault_valid_q   <= 1'b0;
      fault_addr_q    <= '0;
      fault_ch_q      <= '0;
    end else begin
      regions_q       <= regions_d;
      cfg_err_q       <= cfg_err_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_grant_q     <= rsp_grant_d;
      rsp_uncached_q  <= rsp_uncached_d;
      rsp_memregion_q <= rsp_memregion_d;
      rsp_region_q    <= rsp_region_d;
      fault_valid_q   <= fault_valid_d;
      fault_addr_q    <= fault_addr_d;
      fault_ch_q      <= fault_ch_d;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_grant_o     = rsp_grant_q;
  assign rsp_uncached_o  = rsp_uncached_q;
  assign rsp_memregion_o = rsp_memregion_q;
  assign rsp_region_o    = rsp_region_q;
  assign cfg_err_o       = cfg_err_q;
  assign fault_valid_o   = fault_valid_q;
  assign fault_addr_o    = fault_addr_q;
  assign fault_ch_o      = fault_ch_q;

endmodule

// File: tb/tb_pma_unit.sv
// Directed self-checking bench for pma_unit (8 regions, 2 channels).
module tb_pma_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i, req_ready_o;
  logic [63:0] req_addr_i;
  logic [3:0]  req_acc_i;
  logic [1:0]  rsp_valid_o, rsp_ready_i, rsp_grant_o, rsp_uncached_o, rsp_memregion_o;
  logic [5:0]  rsp_region_o;
  logic        cfg_we_i;
  logic [2:0]  cfg_idx_i;
  logic [1:0]  cfg_sel_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_err_o, fault_valid_o, fault_ch_o, fault_clr_i;
  logic [31:0] fault_addr_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  pma_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_acc_i       (req_acc_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_grant_o     (rsp_grant_o),
    .rsp_uncached_o  (rsp_uncached_o),
    .rsp_memregion_o (rsp_memregion_o),
    .rsp_region_o    (rsp_region_o),
    .cfg_we_i        (cfg_we_i),
    .cfg_idx_i       (cfg_idx_i),
    .cfg_sel_i       (cfg_sel_i),
    .cfg_wdata_i     (cfg_wdata_i),
    .cfg_err_o       (cfg_err_o),
    .fault_valid_o   (fault_valid_o),
    .fault_addr_o    (fault_addr_o),
    .fault_ch_o      (fault_ch_o),
    .fault_clr_i     (fault_clr_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] data);
    cfg_we_i    = 1'b1;
    cfg_idx_i   = idx;
    cfg_sel_i   = sel;
    cfg_wdata_i = data;
    tick();
    cfg_we_i = 1'b0;
  endtask

  // One-cycle request; on return the registered response is visible.
  task automatic issue(input int ch, input logic [31:0] addr, input logic [1:0] acc);
    req_valid_i[ch]          = 1'b1;
    req_addr_i[ch*32 +: 32]  = addr;
    req_acc_i[ch*2 +: 2]     = acc;
    tick();
    req_valid_i[ch] = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (rsp_valid_o !== 2'b00) begin fails++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid_o); end
    tests++; if (req_ready_o !== 2'b11) begin fails++; $display("FAIL rst_req_ready: got %b want 11", req_ready_o); end
    tests++; if (fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0 || fault_ch_o !== 1'b0) begin
      fails++; $display("FAIL rst_fault: got v=%b a=%h c=%b want 0/0/0", fault_valid_o, fault_addr_o, fault_ch_o); end
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err_o); end
    issue(0, 32'h4000_1234, 2'd2);
    tests++; if (rsp_valid_o[0] !== 1'b1) begin fails++; $display("FAIL t1_valid: got %b want 1", rsp_valid_o[0]); end
    tests++; if (rsp_grant_o[0] !== 1'b1 || rsp_memregion_o[0] !== 1'b1 || rsp_uncached_o[0] !== 1'b0) begin
      fails++; $display("FAIL t1_attr: got g=%b m=%b u=%b want 1/1/0", rsp_grant_o[0], rsp_memregion_o[0], rsp_uncached_o[0]); end
    tests++; if (rsp_region_o[2:0] !== 3'd0) begin fails++; $display("FAIL t1_region: got %0d want 0", rsp_region_o[2:0]); end
    tests++; if (fault_valid_o !== 1'b0) begin fails++; $display("FAIL t1_nofault: got %b want 0", fault_valid_o); end
    tick();
    tests++; if (rsp_valid_o[0] !== 1'b0) begin fails++; $display("FAIL t1_consumed: got %b want 0", rsp_valid_o[0]); end
  endtask

  task automatic test_program();
    cfg_write(3'd1, 2'd0, 32'h2000_0000);
    cfg_write(3'd1, 2'd1, 32'h0000_000F);
    cfg_write(3'd1, 2'd2, 32'h0000_0023);
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL t2_cfg_err: got %b want 0", cfg_err_o); end
    issue(1, 32'h2000_0004, 2'd1);
    tests++; if (rsp_grant_o[1] !== 1'b1 || rsp_region_o[5:3] !== 3'd1) begin
      fails++; $display("FAIL t2_w: got g=%b r=%0d want 1/1", rsp_grant_o[1], rsp_region_o[5:3]); end
    tests++; if (rsp_uncached_o[1] !== 1'b0 || rsp_memregion_o[1] !== 1'b0) begin
      fails++; $display("FAIL t2_w_attr: got u=%b m=%b want 0/0", rsp_uncached_o[1], rsp_memregion_o[1]); end
    tests++; if (fault_valid_o !== 1'b0) begin fails++; $display("FAIL t2_w_nofault: got %b want 0", fault_valid_o); end
    issue(1, 32'h2000_0004, 2'd2);
    tests++; if (rsp_valid_o[1] !== 1'b1 || rsp_grant_o[1] !== 1'b0) begin
      fails++; $display("FAIL t2_x: got v=%b g=%b want 1/0", rsp_valid_o[1], rsp_grant_o[1]); end
    tests++; if (fault_valid_o !== 1'b1 || fault_addr_o !== 32'h2000_0004 || fault_ch_o !== 1'b1) begin
      fails++; $display("FAIL t2_fault: got v=%b a=%h c=%b want 1/20000004/1", fault_valid_o, fault_addr_o, fault_ch_o); end
    tick();
  endtask

  task automatic test_lock();
    cfg_write(3'd1, 2'd2, 32'h0000_00A3);
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL t3_lock_err: got %b want 0", cfg_err_o); end
    cfg_write(3'd1, 2'd1, 32'h0000_00FF);
    tests++; if (cfg_err_o !== 1'b1) begin fails++; $display("FAIL t3_err_pulse: got %b want 1", cfg_err_o); end
    tick();
    tests++; if (cfg_err_o !== 1'b0) begin fails++; $display("FAIL t3_err_once: got %b want 0", cfg_err_o); end
    cfg_write(3'd2, 2'd3, 32'h1234_5678);
    tests++; if (cfg_err_o !== 1'b1) begin fails++; $display("FAIL t3_sel3_err: got %b want 1", cfg_err_o); end
    // Would match region 1 only if the locked mask had been overwritten.
    issue(0, 32'h2000_0010, 2'd0);
    tests++; if (rsp_grant_o[0] !== 1'b0 || rsp_region_o[2:0] !== 3'd0) begin
      fails++; $display("FAIL t3_mask_kept: got g=%b r=%0d want 0/0", rsp_grant_o[0], rsp_region_o[2:0]); end
    issue(0, 32'h2000_0008, 2'd0);
    tests++; if (rsp_grant_o[0] !== 1'b1 || rsp_region_o[2:0] !== 3'd1) begin
      fails++; $display("FAIL t3_old_match: got g=%b r=%0d want 1/1", rsp_grant_o[0], rsp_region_o[2:0]); end
    tick();
  endtask

  task automatic test_dual_fault();
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    tests++; if (fault_valid_o !== 1'b0) begin fails++; $display("FAIL t4_pre_clr: got %b want 0", fault_valid_o); end
    req_valid_i = 2'b11;
    req_addr_i  = {32'h6000_0000, 32'h5000_0000};
    req_acc_i   = 4'b0000;
    tick();
    req_valid_i = 2'b00;
    tests++; if (rsp_valid_o !== 2'b11 || rsp_grant_o !== 2'b00) begin
      fails++; $display("FAIL t4_rsp: got v=%b g=%b want 11/00", rsp_valid_o, rsp_grant_o); end
    tests++; if (rsp_uncached_o !== 2'b11 || rsp_memregion_o !== 2'b00 || rsp_region_o !== 6'd0) begin
      fails++; $display("FAIL t4_nomatch: got u=%b m=%b r=%h want 11/00/0", rsp_uncached_o, rsp_memregion_o, rsp_region_o); end
    tests++; if (fault_valid_o !== 1'b1 || fault_ch_o !== 1'b0 || fault_addr_o !== 32'h5000_0000) begin
      fails++; $display("FAIL t4_fault: got v=%b c=%b a=%h want 1/0/50000000", fault_valid_o, fault_ch_o, fault_addr_o); end
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    tests++; if (fault_valid_o !== 1'b0) begin fails++; $display("FAIL t4_clr: got %b want 0", fault_valid_o); end
  endtask

  task automatic test_back_to_back();
    rsp_ready_i[0] = 1'b0;
    issue(0, 32'h5000_0000, 2'd0);
    req_valid_i[0]    = 1'b1;
    req_addr_i[31:0]  = 32'h4000_0010;
    req_acc_i[1:0]    = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tests++; if (req_ready_o[0] !== 1'b0) begin fails++; $display("FAIL t5_stall_ready[%0d]: got %b want 0", i, req_ready_o[0]); end
      tests++; if (rsp_valid_o[0] !== 1'b1 || rsp_uncached_o[0] !== 1'b1 || rsp_grant_o[0] !== 1'b0) begin
        fails++; $display("FAIL t5_hold[%0d]: got v=%b u=%b g=%b want 1/1/0", i, rsp_valid_o[0], rsp_uncached_o[0], rsp_grant_o[0]); end
      tick();
    end
    rsp_ready_i[0] = 1'b1;
    #1;
    tests++; if (req_ready_o[0] !== 1'b1) begin fails++; $display("FAIL t5_release_ready: got %b want 1", req_ready_o[0]); end
    tick();
    req_valid_i[0] = 1'b0;
    tests++; if (rsp_valid_o[0] !== 1'b1 || rsp_grant_o[0] !== 1'b1 || rsp_uncached_o[0] !== 1'b0) begin
      fails++; $display("FAIL t5_next_rsp: got v=%b g=%b u=%b want 1/1/0", rsp_valid_o[0], rsp_grant_o[0], rsp_uncached_o[0]); end
    tick();
    tests++; if (rsp_valid_o[0] !== 1'b0) begin fails++; $display("FAIL t5_drained: got %b want 0", rsp_valid_o[0]); end
  endtask

  task automatic test_reset_mid();
    rsp_ready_i = 2'b00;
    issue(1, 32'h2000_0004, 2'd1);
    tests++; if (rsp_valid_o[1] !== 1'b1 || fault_valid_o !== 1'b1) begin
      fails++; $display("FAIL t6_pre: got v=%b f=%b want 1/1", rsp_valid_o[1], fault_valid_o); end
    rst_ni = 1'b0;
    #2;
    tests++; if (rsp_valid_o !== 2'b00 || rsp_grant_o !== 2'b00 || rsp_uncached_o !== 2'b00 ||
                 rsp_memregion_o !== 2'b00 || rsp_region_o !== 6'd0) begin
      fails++; $display("FAIL t6_rsp_rst: got v=%b g=%b u=%b m=%b r=%h want all 0", rsp_valid_o, rsp_grant_o,
                        rsp_uncached_o, rsp_memregion_o, rsp_region_o); end
    tests++; if (fault_valid_o !== 1'b0 || fault_addr_o !== 32'h0 || fault_ch_o !== 1'b0 || cfg_err_o !== 1'b0) begin
      fails++; $display("FAIL t6_fault_rst: got v=%b a=%h c=%b e=%b want all 0", fault_valid_o, fault_addr_o,
                        fault_ch_o, cfg_err_o); end
    tick();
    rst_ni      = 1'b1;
    rsp_ready_i = 2'b11;
    tick();
    issue(1, 32'h2000_0004, 2'd1);
    tests++; if (rsp_grant_o[1] !== 1'b0 || rsp_uncached_o[1] !== 1'b1 || rsp_region_o[5:3] !== 3'd0) begin
      fails++; $display("FAIL t6_r1_disabled: got g=%b u=%b r=%0d want 0/1/0", rsp_grant_o[1], rsp_uncached_o[1], rsp_region_o[5:3]); end
    issue(0, 32'h400F_FFFC, 2'd1);
    tests++; if (rsp_grant_o[0] !== 1'b1 || rsp_region_o[2:0] !== 3'd0) begin
      fails++; $display("FAIL t6_r0_ok: got g=%b r=%0d want 1/0", rsp_grant_o[0], rsp_region_o[2:0]); end
    tick();
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_acc_i   = '0;
    rsp_ready_i = 2'b11;
    cfg_we_i    = 1'b0;
    cfg_idx_i   = '0;
    cfg_sel_i   = '0;
    cfg_wdata_i = '0;
    fault_clr_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    test_reset();
    test_program();
    test_lock();
    test_dual_fault();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
